pmem_rr_arbiter: RTL
====================

Name: pmem_rr_arbiter

Overview:
- Parametrised N-channel arbiter between cache-side line requesters (I-cache, D-cache, prefetcher, ...) and one burst-oriented physical memory port.
- Round-robin grant replaces fixed priority; the line-to-burst serialiser is built in.
- Each request moves one full line (LINE_W bits) as BURSTS = LINE_W/BURST_W beats.
- Sits between the L1 caches and pmem in the mp4 top level.

Parameters:
- NUM_CH, 2, number of requesting channels (>=2); channel 0 has priority after reset.
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, pmem data beat width; LINE_W must be an integer multiple of BURST_W.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ch_address  in  NUM_CH*ADDR_W  per-channel line address; channel i at [i*ADDR_W +: ADDR_W].
- ch_read  in  NUM_CH  per-channel read request, held until that channel's resp.
- ch_write  in  NUM_CH  per-channel write request, held until that channel's resp.
- ch_wdata  in  NUM_CH*LINE_W  per-channel write line.
- ch_rdata  out  LINE_W  returned read line, shared by all channels; valid when a resp bit is high.
- ch_resp  out  NUM_CH  one-hot, single-cycle completion pulse.
- pmem_rdata  in  BURST_W  read beat.
- pmem_resp  in  1  beat accepted (write) or valid (read).
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_wdata  out  BURST_W  write beat.
- pmem_address  out  ADDR_W  burst address.

Behaviour:
- States: IDLE, GRANT, RBURST, WBURST, DONE.
- Reset:
  - State goes to IDLE; round-robin pointer ptr=0; beat counter=0; captured line=0.
  - Outputs: pmem_read=0, pmem_write=0, ch_resp=0, pmem_address=0, pmem_wdata=0, ch_rdata=0.
- IDLE:
  - Channel i is requesting if ch_read[i]|ch_write[i].
  - Grant goes to the first requesting channel found scanning ptr, ptr+1, ... mod NUM_CH.
  - On the grant, latch gnt, the address, op (read wins if both read and write are set) and wdata, then go to GRANT.
  - With no requests, stay in IDLE.
- GRANT: one cycle. Drive pmem_address from the latched address; clear the counter; go to RBURST or WBURST.
- RBURST:
  - pmem_read=1 continuously and pmem_address stable.
  - Each cycle with pmem_resp=1: line[cnt*BURST_W +: BURST_W] <= pmem_rdata, cnt++.
  - When cnt==BURSTS-1 and pmem_resp=1, go to DONE.
- WBURST:
  - pmem_write=1 and pmem_wdata = latched_wdata[cnt*BURST_W +: BURST_W].
  - cnt advances on pmem_resp; the last beat goes to DONE.
- DONE:
  - ch_resp[gnt]=1 for exactly one cycle; ch_rdata=line (reads); pmem_read and pmem_write are 0.
  - ptr <= (gnt+1) mod NUM_CH; go to IDLE.
- Consequences:
  - A requester deasserts its request in the cycle after its resp, and IDLE re-samples requests a cycle later, so no double service.
  - Minimum latency from request to resp is 3+BURSTS cycles with pmem_resp tied high.
- Requests are ignored outside IDLE. A channel that raises a request mid-burst waits; no preemption.
- Simultaneous requests: each requesting channel is served once before any channel is served twice (starvation-free, bounded by NUM_CH transactions).
- A channel deasserting its request after grant is illegal; the burst still completes and resp still pulses.
- pmem_resp outside RBURST/WBURST is ignored.
- Counter is $clog2(BURSTS) bits wide (1 bit minimum); no wrap beyond BURSTS-1.
- Reset asserted mid-burst: immediate return to the reset values, and the partial line is discarded.
- ch_rdata holds the last read line until the next read completes.

Test Plan (NUM_CH=2, LINE_W=256, BURST_W=64):
- Single read: ch_read=2'b01, addr0=0x0000_1000; pmem returns beats 0x11..,0x22..,0x33..,0x44.. with resp high. Required: pmem_read high 4 cycles at addr 0x1000; ch_resp=2'b01 one cycle; ch_rdata={0x44..,0x33..,0x22..,0x11..}; total 7 cycles.
- Single write: ch_write[1]=1, wdata1=0xDDDD..CCCC..BBBB..AAAA.., pmem_resp stalls 2 cycles before each beat. Required: pmem_wdata steps through AAAA, BBBB, CCCC, DDDD, changing only after each resp; ch_resp=2'b10.
- Contention: both channels request continuously for 4 transactions starting from reset. Required: grant order 0, 1, 0, 1, and no resp ever goes to the same channel twice in a row.
- Late arrival: ch1 raises a read during ch0's RBURST. Required: ch0 completes uninterrupted, then ch1 is granted in the next IDLE.
- Reset mid-burst: assert rst after 2 read beats. Required: pmem_read=0 and ch_resp=0 immediately; ptr=0. A fresh read then returns the correct full line.
- Read+write both set on ch0: required a read burst with pmem_write never asserted.

Source files
------------

// File: rtl/pmem_rr_arbiter_if.sv
// Bundle of the per-channel cache request bus and the burst pmem port
// seen by the round-robin line arbiter.
interface pmem_rr_arbiter_if #(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
);
    logic [NUM_CH*ADDR_W-1:0] ch_address;
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [LINE_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_resp;

    logic [BURST_W-1:0]       pmem_rdata;
    logic                     pmem_resp;
    logic                     pmem_read;
    logic                     pmem_write;
    logic [BURST_W-1:0]       pmem_wdata;
    logic [ADDR_W-1:0]        pmem_address;

    // Arbiter side.
    modport master (
        input  ch_address, ch_read, ch_write, ch_wdata, pmem_rdata, pmem_resp,
        output ch_rdata, ch_resp, pmem_read, pmem_write, pmem_wdata, pmem_address
    );

    // Caches plus physical memory side.
    modport slave (
        output ch_address, ch_read, ch_write, ch_wdata, pmem_rdata, pmem_resp,
        input  ch_rdata, ch_resp, pmem_read, pmem_write, pmem_wdata, pmem_address
    );
endinterface

// File: rtl/pmem_rr_arbiter.sv
// Round-robin arbiter from NUM_CH cache line requesters onto one burst pmem
// port, with the line <-> beat serialiser built in.
module pmem_rr_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    pmem_rr_arbiter_if.master   bus
);
    localparam int BURSTS = LINE_W / BURST_W;
    localparam int CNT_W  = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int PTR_W  = $clog2(NUM_CH);

    typedef enum logic [2:0] {IDLE, GRANT, RBURST, WBURST, DONE} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    ptr, gnt, sel, idx;
    logic                any_req;
    logic [NUM_CH-1:0]   req;
    logic [CNT_W-1:0]    cnt;
    logic                last_beat;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_q;
    logic [LINE_W-1:0]   wdata_q, line_q, rdata_q;

    assign req       = bus.ch_read | bus.ch_write;
    assign last_beat = bus.pmem_resp && (cnt == CNT_W'(BURSTS - 1));

    // Scan downwards from ptr+NUM_CH-1 so the last hit, i.e. the channel
    // closest to ptr, is the one that sticks.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_CH);
            if (req[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt        = state;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_wdata   = '0;
        bus.pmem_address = addr_q;
        bus.ch_resp      = '0;
        bus.ch_rdata     = rdata_q;
        unique case (state)
            IDLE:   if (any_req) state_nxt = GRANT;
            GRANT:  state_nxt = rd_q ? RBURST : WBURST;
            RBURST: begin
                bus.pmem_read = 1'b1;
                if (last_beat) state_nxt = DONE;
            end
            WBURST: begin
                bus.pmem_write = 1'b1;
                bus.pmem_wdata = wdata_q[cnt*BURST_W +: BURST_W];
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                bus.ch_resp = NUM_CH'(1) << gnt;
                if (rd_q) bus.ch_rdata = line_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the line buffers are plain flops, not RAM, so they take the async
    // reset too; a reset mid-burst therefore drops any partial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            gnt     <= '0;
            cnt     <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every register sees the
            // pre-edge value of cnt and state regardless of statement order.
            unique case (state)
                IDLE: if (any_req) begin
                    gnt     <= sel;
                    addr_q  <= bus.ch_address[sel*ADDR_W +: ADDR_W];
                    rd_q    <= bus.ch_read[sel];
                    wdata_q <= bus.ch_wdata[sel*LINE_W +: LINE_W];
                end
                GRANT: cnt <= '0;
                RBURST: if (bus.pmem_resp) begin
                    line_q[cnt*BURST_W +: BURST_W] <= bus.pmem_rdata;
                    if (!last_beat) cnt <= cnt + 1'b1;
                end
                WBURST: if (bus.pmem_resp && !last_beat) cnt <= cnt + 1'b1;
                DONE: begin
                    ptr <= (gnt == PTR_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
                    if (rd_q) rdata_q <= line_q;
                end
                default: ;
            endcase
        end
    end
endmodule
